// File: rtl/kia_scan_decoder_if.sv
// Wishbone link between the scan decoder (master) and the KIA keyboard adapter (slave).
//   adr : register select, 0 = status/pop, 1 = queue head
//   we  : write strobe; a write to adr 0 pops the KIA queue
//   cyc : bus cycle
//   stb : strobe, always asserted together with cyc
//   ack : slave acknowledge, ends the cycle on the edge where it is high
//   dat : read data from the KIA; status bit0 = empty, bit1 = full
interface kia_scan_decoder_if;
  logic       adr;
  logic       we;
  logic       cyc;
  logic       stb;
  logic       ack;
  logic [7:0] dat;

  modport master (
    output adr,
    output we,
    output cyc,
    output stb,
    input  ack,
    input  dat
  );

  modport slave (
    input  adr,
    input  we,
    input  cyc,
    input  stb,
    output ack,
    output dat
  );
endinterface

// File: rtl/kia_scan_decoder.sv
// PS/2 set-2 scan code decoder sitting behind the KIA keyboard adapter.
// Polls the KIA status register, reads and pops each queued byte, folds E0/F0/E1 prefixes
// into single key events and tracks modifier state.
//   CLK_I      : clock, rising edge
//   RES_I      : synchronous active-high reset
//   wb         : Wishbone master port towards the KIA (ADR/WE/CYC/STB out, ACK/DAT in)
//   EV_CODE_O  : scan code of the event, prefixes stripped
//   EV_EXT_O   : event was E0-prefixed
//   EV_BRK_O   : event is a key release (F0-prefixed)
//   EV_VALID_O : event available, held until EV_READY_I
//   EV_READY_I : consumer accepts the event
//   MOD_O      : {caps_lock, alt, ctrl, rshift, lshift}
//   ERR_O      : one-cycle pulse when a 0x00/0xFF error byte is discarded
module kia_scan_decoder #(
  parameter int unsigned POLL_GAP   = 16,
  parameter int unsigned PAUSE_SKIP = 7
) (
  input  logic               CLK_I,
  input  logic               RES_I,
  kia_scan_decoder_if.master wb,
  output logic [7:0]         EV_CODE_O,
  output logic               EV_EXT_O,
  output logic               EV_BRK_O,
  output logic               EV_VALID_O,
  input  logic               EV_READY_I,
  output logic [4:0]         MOD_O,
  output logic               ERR_O
);

  localparam logic [7:0] GapLast  = 8'(POLL_GAP - 1);
  localparam logic [7:0] SkipLoad = 8'(PAUSE_SKIP);

  localparam logic [7:0] CodeExt   = 8'hE0;
  localparam logic [7:0] CodeBrk   = 8'hF0;
  localparam logic [7:0] CodePause = 8'hE1;
  localparam logic [7:0] CodeErrLo = 8'h00;
  localparam logic [7:0] CodeErrHi = 8'hFF;
  localparam logic [7:0] CodeLsh   = 8'h12;
  localparam logic [7:0] CodeRsh   = 8'h59;
  localparam logic [7:0] CodeCtrl  = 8'h14;
  localparam logic [7:0] CodeAlt   = 8'h11;
  localparam logic [7:0] CodeCaps  = 8'h58;

  localparam int unsigned ModLsh  = 0;
  localparam int unsigned ModRsh  = 1;
  localparam int unsigned ModCtrl = 2;
  localparam int unsigned ModAlt  = 3;
  localparam int unsigned ModCaps = 4;

  typedef enum logic [2:0] {
    StPoll,
    StGap,
    StRead,
    StPop,
    StEmit
  } state_e;

  state_e     state_q, state_d;
  logic       cyc_q, cyc_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] byte_q, byte_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [7:0] skip_q, skip_d;
  logic [7:0] ev_code_q, ev_code_d;
  logic       ev_ext_q, ev_ext_d;
  logic       ev_brk_q, ev_brk_d;
  logic [4:0] mod_q, mod_d;
  logic       caps_down_q, caps_down_d;
  logic       err_q, err_d;
  logic       make;

  assign make = ~brk_q;

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    gap_d       = gap_q;
    byte_d      = byte_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    skip_d      = skip_q;
    ev_code_d   = ev_code_q;
    ev_ext_d    = ev_ext_q;
    ev_brk_d    = ev_brk_q;
    mod_d       = mod_q;
    caps_down_d = caps_down_q;
    err_d       = 1'b0;

    unique case (state_q)
      // Each bus state spends its first cycle with CYC low, which gives the mandatory idle
      // cycle between back-to-back transactions.
      StPoll: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
        end else if (wb.ack) begin
          cyc_d = 1'b0;
          if (wb.dat[0]) begin
            state_d = StGap;
            gap_d   = 8'd0;
          end else begin
            state_d = StRead;
          end
        end
      end

      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StPoll;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      StRead: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
        end else if (wb.ack) begin
          cyc_d   = 1'b0;
          byte_d  = wb.dat;
          state_d = StPop;
        end
      end

      StPop: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
        end else if (wb.ack) begin
          cyc_d   = 1'b0;
          state_d = StPoll;
          if (skip_q != 8'd0) begin
            // Tail of a Pause sequence: drop without touching the prefix flags.
            skip_d = skip_q - 8'd1;
          end else begin
            case (byte_q)
              CodeExt: ext_d = 1'b1;
              CodeBrk: brk_d = 1'b1;
              CodePause: begin
                skip_d = SkipLoad;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
              end
              CodeErrLo, CodeErrHi: begin
                err_d = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
              end
              default: begin
                state_d   = StEmit;
                ev_code_d = byte_q;
                ev_ext_d  = ext_q;
                ev_brk_d  = brk_q;
                ext_d     = 1'b0;
                brk_d     = 1'b0;
                case (byte_q)
                  CodeLsh:  mod_d[ModLsh]  = make;
                  CodeRsh:  mod_d[ModRsh]  = make;
                  CodeCtrl: mod_d[ModCtrl] = make;
                  CodeAlt:  mod_d[ModAlt]  = make;
                  CodeCaps: begin
                    // caps_down masks typematic repeats so only a fresh press toggles.
                    if (!make) begin
                      caps_down_d = 1'b0;
                    end else if (!caps_down_q) begin
                      mod_d[ModCaps] = ~mod_q[ModCaps];
                      caps_down_d    = 1'b1;
                    end
                  end
                  default: ;
                endcase
              end
            endcase
          end
        end
      end

      StEmit: begin
        // Start the next status poll straight away; CYC was already low throughout EMIT.
        if (EV_READY_I) begin
          state_d = StPoll;
          cyc_d   = 1'b1;
        end
      end

      default: begin
        state_d = StPoll;
        cyc_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RES_I) begin
      state_q     <= StPoll;
      cyc_q       <= 1'b0;
      gap_q       <= 8'd0;
      byte_q      <= 8'd0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      skip_q      <= 8'd0;
      ev_code_q   <= 8'd0;
      ev_ext_q    <= 1'b0;
      ev_brk_q    <= 1'b0;
      mod_q       <= 5'd0;
      caps_down_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      gap_q       <= gap_d;
      byte_q      <= byte_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      skip_q      <= skip_d;
      ev_code_q   <= ev_code_d;
      ev_ext_q    <= ev_ext_d;
      ev_brk_q    <= ev_brk_d;
      mod_q       <= mod_d;
      caps_down_q <= caps_down_d;
      err_q       <= err_d;
    end
  end

  // ADR/WE derive from the state, which cannot change while CYC is high.
  assign wb.cyc = cyc_q;
  assign wb.stb = cyc_q;
  assign wb.adr = cyc_q & (state_q == StRead);
  assign wb.we  = cyc_q & (state_q == StPop);

  assign EV_CODE_O  = ev_code_q;
  assign EV_EXT_O   = ev_ext_q;
  assign EV_BRK_O   = ev_brk_q;
  assign EV_VALID_O = (state_q == StEmit);
  assign MOD_O      = mod_q;
  assign ERR_O      = err_q;

endmodule

// File: doc/kia_scan_decoder.md
Name: kia_scan_decoder

Overview:
- Wishbone master directly downstream of the KIA keyboard interface adapter. Polls KIA status, reads and pops queued PS/2 set-2 scan codes, then folds the E0/F0/E1 prefixes into single key events.
- Presents each event on a valid/ready port and tracks modifier state.
- Sits between the KIA slave and the CPU-side key event consumer, which is typically a small FIFO or an interrupt latch.

Parameters:
- POLL_GAP, 16, idle cycles between status polls that returned empty (1..255).
- PAUSE_SKIP, 7, bytes discarded after an E1 prefix (Pause key sequence).

Ports:
- CLK_I  in  1  system clock; all logic on the rising edge.
- RES_I  in  1  synchronous, active-high reset.
- ADR_O  out  1  KIA register select: 0 = status/pop, 1 = queue head.
- WE_O  out  1  write strobe; a write to ADR 0 pops the KIA queue (data ignored).
- CYC_O  out  1  Wishbone cycle.
- STB_O  out  1  Wishbone strobe.
- ACK_I  in  1  slave acknowledge.
- DAT_I  in  8  KIA read data; status bit0 = empty, bit1 = full.
- EV_CODE_O  out  8  scan code of the event (prefix bytes stripped).
- EV_EXT_O  out  1  event was E0-prefixed.
- EV_BRK_O  out  1  event is a release (F0-prefixed).
- EV_VALID_O  out  1  event available.
- EV_READY_I  in  1  consumer accepts the event.
- MOD_O  out  5  {caps_lock, alt, ctrl, rshift, lshift}.
- ERR_O  out  1  one-cycle pulse when a 0x00 or 0xFF (KIA/keyboard error) byte is discarded.

Behaviour:
- Reset (RES_I=1 at an edge):
  - Next cycle: CYC_O=STB_O=WE_O=0, ADR_O=0, EV_VALID_O=0, EV_CODE_O=0, EV_EXT_O=EV_BRK_O=0, MOD_O=0, ERR_O=0.
  - Prefix flags, skip counter and gap counter cleared; state=POLL.
  - Reset overrides everything, including a bus cycle in progress (that cycle is abandoned) and a pending event (dropped).
- Bus rules:
  - CYC_O=STB_O asserted together.
  - ADR_O/WE_O stable for the whole cycle.
  - A cycle ends on the edge where ACK_I=1. DAT_I is captured on that edge.
  - Wait states are unbounded.
  - CYC_O is low for at least one cycle between transactions.
- FSM states: POLL, GAP, READ, POP, EMIT.
  - POLL: read ADR 0. On ACK:
    - DAT_I[0]=1 -> GAP.
    - else -> READ.
  - GAP: count POLL_GAP idle cycles -> POLL.
  - READ: read ADR 1; latch byte on ACK -> POP.
  - POP: write ADR 0. On ACK, classify the latched byte:
    - skip counter nonzero: decrement, discard -> POLL.
    - E0: set ext -> POLL.
    - F0: set brk -> POLL.
    - E1: load skip=PAUSE_SKIP, clear ext/brk -> POLL.
    - 00 or FF: pulse ERR_O, clear ext/brk -> POLL.
    - any other byte: load EV_* outputs, update MOD_O, clear ext/brk -> EMIT.
  - EMIT: EV_VALID_O=1, outputs held stable. On an edge with EV_READY_I=1 -> POLL, and EV_VALID_O is 0 next cycle.
    - No bus activity while in EMIT. Backpressure is carried by the KIA queue.
- Latency with a zero-wait slave (ACK in the strobe cycle):
  - Status strobe at cycle 0, read at cycle 2, pop at cycle 4; EV_VALID_O high from cycle 5.
  - Earliest next poll is the cycle after acceptance.
- Modifiers, updated on the POP->EMIT edge and visible with EV_VALID_O:
  - lshift = code 12; rshift = 59; ctrl = 14 (ext or not); alt = 11 (ext or not). Each set on make, cleared on break.
  - Ctrl and alt are shared between the left and right keys: the last event wins.
  - caps_lock toggles on a make of 58 only if the caps key was up. A hidden caps_down bit suppresses typematic repeats; a break of 58 clears it.
- Both E0 and F0 prefixes accumulate in any order before the code byte, e.g. E0 F0 14 -> ext=1, brk=1.
- A prefix-only stream never emits an event.

Test Plan:
- Reset, KIA model empty (status 01) -> POLL strobes spaced POLL_GAP+1 idle cycles apart; never ADR 1; EV_VALID_O stays 0; MOD_O=0.
- Queue holds 1C, zero-wait slave -> read ADR 1, then write ADR 0; EV_VALID_O at cycle 5 with CODE=1C, EXT=0, BRK=0; held until EV_READY_I=1.
- Queue E0 F0 14 -> a single event: CODE=14, EXT=1, BRK=1; ctrl follows make/break.
- Queue 12, 58, 58, F0 58, 58 -> lshift=1; caps_lock=1 after the first 58; unchanged by the repeat; still 1 after F0 58; 0 after the final 58; five events total.
- Queue E1 14 77 E1 F0 14 F0 77 1B, PAUSE_SKIP=7 -> only CODE=1B is emitted; queue 00 -> ERR_O pulses once, no event.
- Slave inserts 3 wait states, EV_READY_I held low 10 cycles, then RES_I asserted during a READ -> CYC_O held until ACK; no further bus cycles while EMIT; after RES_I all outputs return to reset values next cycle.
